// File: rtl/uart_rx_edge_bit_sampler.sv
// Oversampling front end of the UART receiver: line conditioning, edge/bit counters and
// three-sample majority vote around the bit centre. Define UART_RX_SYNC_EN for a 2-flop RX_IN sync.
module uart_rx_edge_bit_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic [5:0] prescale,
  input  logic       count_enable,
  input  logic       dat_samp_en,
  output logic       rx_line,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       samp_valid
);

  localparam logic StIdle  = 1'b0;
  localparam logic StCount = 1'b1;

  logic       state_q, state_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       samp_q, samp_d;
  logic       valid_q, valid_d;

  logic [5:0] half;
  logic [5:0] half_m1;
  logic [5:0] half_p1;
  logic       samp_active;
  logic       vote;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_line = sync2_q;
`else
  assign rx_line = RX_IN;
`endif

  // >= rather than == so a mid-bit drop of prescale still wraps the bit.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    if (!count_enable) begin
      state_d = StIdle;
      edge_d  = 6'd0;
      bit_d   = 4'd0;
    end else if (state_q == StIdle) begin
      state_d = StCount;
      edge_d  = 6'd1;
      bit_d   = 4'd1;
    end else if (edge_q >= prescale) begin
      edge_d = 6'd1;
      if (bit_q != 4'd15) begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      edge_d = edge_q + 6'd1;
    end
  end

  assign half        = prescale >> 1;
  assign half_m1     = half - 6'd1;
  assign half_p1     = half + 6'd1;
  // edge_q is still 0 in the first enabled cycle; only sample once truly counting.
  assign samp_active = count_enable & dat_samp_en & (state_q == StCount);
  assign vote        = (s0_q & s1_q) | (s0_q & rx_line) | (s1_q & rx_line);

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    samp_d  = samp_q;
    valid_d = 1'b0;
    if (samp_active) begin
      if (edge_q == half_m1) begin
        s0_d = rx_line;
      end
      if (edge_q == half) begin
        s1_d = rx_line;
      end
      if (edge_q == half_p1) begin
        samp_d  = vote;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      edge_q  <= 6'd0;
      bit_q   <= 4'd0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      samp_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
    end
  end

  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign sampled_bit = samp_q;
  assign samp_valid  = valid_q;

endmodule
